// File: rtl/ex_alu_unit_if.sv
// Bundle of the ID/EX-side inputs and registered EX/MA-side outputs of ex_alu_unit.
// Defining EX_ALU_OVERFLOW_EN adds the registered overflow flag to the bundle.
interface ex_alu_unit_if #(parameter int WIDTH = 32);
    logic             en;
    logic [WIDTH-1:0] npc;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic [WIDTH-1:0] imm32;
    logic [5:0]       funct;
    logic [1:0]       alu_op;
    logic             alu_src;

    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_out;
    logic             zero;
    logic [WIDTH-1:0] branch_target;
    logic [WIDTH-1:0] rt_pass;
`ifdef EX_ALU_OVERFLOW_EN
    logic             overflow;

    modport master (
        output en, npc, rs_val, rt_val, imm32, funct, alu_op, alu_src,
        input  alu_ctrl, alu_out, zero, branch_target, rt_pass, overflow
    );

    modport slave (
        input  en, npc, rs_val, rt_val, imm32, funct, alu_op, alu_src,
        output alu_ctrl, alu_out, zero, branch_target, rt_pass, overflow
    );
`else
    modport master (
        output en, npc, rs_val, rt_val, imm32, funct, alu_op, alu_src,
        input  alu_ctrl, alu_out, zero, branch_target, rt_pass
    );

    modport slave (
        input  en, npc, rs_val, rt_val, imm32, funct, alu_op, alu_src,
        output alu_ctrl, alu_out, zero, branch_target, rt_pass
    );
`endif
endinterface

// File: rtl/ex_alu_unit.sv
// Execute stage: ALU-control decode, ALU with zero flag and branch-target adder, all registered.
// Optional macro EX_ALU_OVERFLOW_EN adds a registered signed-overflow flag for add/sub.
module ex_alu_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    ex_alu_unit_if.slave  bus
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic [2:0]       ctrl;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] target;
    logic             ovf;

    always_comb begin
        ctrl = OP_ADD;
        case (bus.alu_op)
            2'b00: ctrl = OP_ADD;
            2'b01: ctrl = OP_SUB;
            2'b11: ctrl = OP_OR;
            2'b10: begin
                case (bus.funct)
                    6'b100000: ctrl = OP_ADD;
                    6'b100010: ctrl = OP_SUB;
                    6'b100100: ctrl = OP_AND;
                    6'b100101: ctrl = OP_OR;
                    6'b100110: ctrl = OP_XOR;
                    6'b100111: ctrl = OP_NOR;
                    6'b101010: ctrl = OP_SLT;
                    default:   ctrl = OP_ADD;
                endcase
            end
            default: ctrl = OP_ADD;
        endcase
    end

    assign op_b = bus.alu_src ? bus.imm32 : bus.rt_val;

    // Unused code 101 falls to the default and yields 0.
    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (ctrl)
            OP_ADD: begin
                result = bus.rs_val + op_b;
                ovf    = (bus.rs_val[WIDTH-1] == op_b[WIDTH-1]) &&
                         (result[WIDTH-1] != bus.rs_val[WIDTH-1]);
            end
            OP_SUB: begin
                result = bus.rs_val - op_b;
                ovf    = (bus.rs_val[WIDTH-1] != op_b[WIDTH-1]) &&
                         (result[WIDTH-1] != bus.rs_val[WIDTH-1]);
            end
            OP_AND:  result = bus.rs_val & op_b;
            OP_OR:   result = bus.rs_val | op_b;
            OP_XOR:  result = bus.rs_val ^ op_b;
            OP_NOR:  result = ~(bus.rs_val | op_b);
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(bus.rs_val) < $signed(op_b))};
            default: result = '0;
        endcase
    end

    assign target = bus.npc + {bus.imm32[WIDTH-3:0], 2'b00};

    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.alu_ctrl      <= '0;
            bus.alu_out       <= '0;
            bus.zero          <= 1'b0;
            bus.branch_target <= '0;
            bus.rt_pass       <= '0;
        end else if (bus.en) begin
            bus.alu_ctrl      <= ctrl;
            bus.alu_out       <= result;
            bus.zero          <= (result == '0);
            bus.branch_target <= target;
            bus.rt_pass       <= bus.rt_val;
        end
    end

`ifdef EX_ALU_OVERFLOW_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.overflow <= 1'b0;
        end else if (bus.en) begin
            bus.overflow <= ovf;
        end
    end
`else
    logic unused_ovf;
    assign unused_ovf = ovf;
`endif

endmodule

// File: tb/tb_ex_alu_unit.sv
// Self-checking bench for ex_alu_unit: directed cases plus randomized traffic against a reference model.
// Build with EX_ALU_OVERFLOW_EN defined to also check the overflow flag.
module tb_ex_alu_unit;

    localparam int W = 32;

    logic clk;
    logic reset;

    ex_alu_unit_if #(.WIDTH(W)) bus ();

    ex_alu_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_compared = 0;
    int n_mismatched = 0;

    typedef enum {M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_NOR, M_SLT} mnem_e;

    typedef struct {
        logic [2:0]   ctrl;
        logic [W-1:0] out;
        logic         zero;
        logic [W-1:0] target;
        logic [W-1:0] rt;
        logic         ovf;
    } exp_t;

    exp_t exp_q = '{default: '0};

    function automatic mnem_e which_op(logic [1:0] aop, logic [5:0] f);
        if (aop == 2'b01) return M_SUB;
        if (aop == 2'b11) return M_OR;
        if (aop == 2'b00) return M_ADD;
        if (f == 6'd32) return M_ADD;
        if (f == 6'd34) return M_SUB;
        if (f == 6'd36) return M_AND;
        if (f == 6'd37) return M_OR;
        if (f == 6'd38) return M_XOR;
        if (f == 6'd39) return M_NOR;
        if (f == 6'd42) return M_SLT;
        return M_ADD;
    endfunction

    function automatic exp_t model(logic [W-1:0] npc, logic [W-1:0] rs, logic [W-1:0] rt,
                                   logic [W-1:0] imm, logic [5:0] f, logic [1:0] aop, logic src);
        exp_t   e;
        mnem_e  m;
        longint sa;
        longint sb;
        longint wide;
        logic [W-1:0] b;
        b  = src ? imm : rt;
        sa = longint'($signed(rs));
        sb = longint'($signed(b));
        m  = which_op(aop, f);
        e.ovf = 1'b0;
        case (m)
            M_ADD: begin
                e.ctrl = 3'd2; wide = sa + sb; e.out = W'(wide);
                e.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            M_SUB: begin
                e.ctrl = 3'd6; wide = sa - sb; e.out = W'(wide);
                e.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            M_AND: begin e.ctrl = 3'd0; e.out = rs & b; end
            M_OR:  begin e.ctrl = 3'd1; e.out = rs | b; end
            M_XOR: begin e.ctrl = 3'd3; e.out = rs ^ b; end
            M_NOR: begin e.ctrl = 3'd4; e.out = ~(rs | b); end
            default: begin e.ctrl = 3'd7; e.out = (sa < sb) ? 1 : 0; end
        endcase
        e.zero   = (e.out == 0);
        e.target = W'(longint'(npc) + longint'(imm) * 4);
        e.rt     = rt;
        return e;
    endfunction

    // The reference register follows the same reset/enable rules as the stage.
    always @(posedge clk) begin
        if (!reset)
            exp_q <= '{default: '0};
        else if (bus.en)
            exp_q <= model(bus.npc, bus.rs_val, bus.rt_val, bus.imm32, bus.funct, bus.alu_op, bus.alu_src);
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst_n, input logic en, input logic [W-1:0] npc,
                                 input logic [W-1:0] rs, input logic [W-1:0] rt, input logic [W-1:0] imm,
                                 input logic [5:0] f, input logic [1:0] aop, input logic src);
        reset          = rst_n;
        bus.en         = en;
        bus.npc        = npc;
        bus.rs_val     = rs;
        bus.rt_val     = rt;
        bus.imm32      = imm;
        bus.funct      = f;
        bus.alu_op     = aop;
        bus.alu_src    = src;
    endtask

    task automatic applyRandom(input logic rst_n, input logic en);
        logic [5:0] f;
        int pick;
        pick = $urandom_range(0, 9);
        case (pick)
            0: f = 6'd32; 1: f = 6'd34; 2: f = 6'd36; 3: f = 6'd37;
            4: f = 6'd38; 5: f = 6'd39; 6: f = 6'd42;
            default: f = 6'($urandom);
        endcase
        applyStimulus(rst_n, en, $urandom, $urandom, ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
                      $urandom, f, 2'($urandom), 1'($urandom));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        checkOutput("alu_ctrl", 64'(bus.alu_ctrl), 64'(exp_q.ctrl));
        checkOutput("alu_out", 64'(bus.alu_out), 64'(exp_q.out));
        checkOutput("zero", 64'(bus.zero), 64'(exp_q.zero));
        checkOutput("branch_target", 64'(bus.branch_target), 64'(exp_q.target));
        checkOutput("rt_pass", 64'(bus.rt_pass), 64'(exp_q.rt));
`ifdef EX_ALU_OVERFLOW_EN
        checkOutput("overflow", 64'(bus.overflow), 64'(exp_q.ovf));
`endif
    endtask

    initial begin
        $display("[TB] start");
        applyRandom(1'b0, 1'b1);
        step();
        applyRandom(1'b0, 1'b1);
        step();
        checkOutput("rst_out", 64'(bus.alu_out), 64'd0);
        checkOutput("rst_target", 64'(bus.branch_target), 64'd0);

        applyStimulus(1, 1, 32'h40, 32'd5, 32'd7, 32'h0, 6'b100000, 2'b10, 0);
        step();
        checkOutput("add_out", 64'(bus.alu_out), 64'd12);
        checkOutput("add_ctrl", 64'(bus.alu_ctrl), 64'b010);
        checkOutput("add_zero", 64'(bus.zero), 64'd0);

        applyStimulus(1, 1, 32'h10, 32'h1234, 32'h1234, 32'hFFFF_FFFE, 6'b0, 2'b01, 0);
        step();
        checkOutput("beq_out", 64'(bus.alu_out), 64'd0);
        checkOutput("beq_zero", 64'(bus.zero), 64'd1);
        checkOutput("beq_target", 64'(bus.branch_target), 64'h8);

        applyStimulus(1, 1, 32'h0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 6'b100100, 2'b10, 0);
        step();
        checkOutput("and_out", 64'(bus.alu_out), 64'h00F0_00F0);
        bus.funct = 6'b100101;
        step();
        checkOutput("or_out", 64'(bus.alu_out), 64'hFFF0_FFF0);
        bus.funct = 6'b100110;
        step();
        checkOutput("xor_out", 64'(bus.alu_out), 64'hFF00_FF00);
        bus.funct = 6'b100111;
        step();
        checkOutput("nor_out", 64'(bus.alu_out), 64'h000F_000F);
        applyStimulus(1, 1, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0, 6'b101010, 2'b10, 0);
        step();
        checkOutput("slt_out", 64'(bus.alu_out), 64'd1);

        applyStimulus(1, 1, 32'h0, 32'h100, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 6'b0, 2'b00, 1);
        step();
        checkOutput("lw_out", 64'(bus.alu_out), 64'hFC);
        checkOutput("sw_data", 64'(bus.rt_pass), 64'hDEAD_BEEF);

        applyRandom(1'b1, 1'b0);
        step();
        checkOutput("hold_out", 64'(bus.alu_out), 64'hFC);
        checkOutput("hold_rt", 64'(bus.rt_pass), 64'hDEAD_BEEF);
        applyRandom(1'b0, 1'b1);
        step();
        checkOutput("rst_prio_out", 64'(bus.alu_out), 64'd0);

        applyStimulus(1, 1, 32'h0, 32'd3, 32'd4, 32'h0, 6'b000000, 2'b10, 0);
        step();
        checkOutput("undef_ctrl", 64'(bus.alu_ctrl), 64'b010);

`ifdef EX_ALU_OVERFLOW_EN
        applyStimulus(1, 1, 32'h0, 32'h7FFF_FFFF, 32'd1, 32'h0, 6'b100000, 2'b10, 0);
        step();
        checkOutput("ovf_add_out", 64'(bus.alu_out), 64'h8000_0000);
        checkOutput("ovf_add", 64'(bus.overflow), 64'd1);
        applyStimulus(1, 1, 32'h0, 32'h8000_0000, 32'd1, 32'h0, 6'b100010, 2'b10, 0);
        step();
        checkOutput("ovf_sub", 64'(bus.overflow), 64'd1);
        applyStimulus(1, 1, 32'h0, 32'd1, 32'd1, 32'h0, 6'b100000, 2'b10, 0);
        step();
        checkOutput("ovf_none", 64'(bus.overflow), 64'd0);
`endif

        for (int i = 0; i < 400; i++) begin
            applyRandom(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) != 0));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
